// File: rtl/mips_ex_pkg.sv
// +--------------------------------------------------------------------------+
// | mips_ex_pkg : shared EX-stage constants, FSM encoding and ALU decode     |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

package mips_ex_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  localparam logic [3:0] SEL_ADD   = 4'b0000;
  localparam logic [3:0] SEL_SUB   = 4'b0001;
  localparam logic [3:0] SEL_AND   = 4'b0010;
  localparam logic [3:0] SEL_OR    = 4'b0011;
  localparam logic [3:0] SEL_SLT   = 4'b0100;
  localparam logic [3:0] SEL_MFHI  = 4'b0101;
  localparam logic [3:0] SEL_MFLO  = 4'b0110;
  localparam logic [3:0] SEL_MULT  = 4'b0111;
  localparam logic [3:0] SEL_MULTU = 4'b1000;
  localparam logic [3:0] SEL_DIV   = 4'b1001;
  localparam logic [3:0] SEL_DIVU  = 4'b1010;
  localparam logic [3:0] SEL_NOP   = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } md_state_e;

  function automatic logic [3:0] decode_sel(input logic [1:0] op, input logic [5:0] fn);
    logic [3:0] sel;
    sel = SEL_NOP;
    case (op)
      ALUOP_ADD: sel = SEL_ADD;
      ALUOP_SUB: sel = SEL_SUB;
      ALUOP_RTYPE: begin
        case (fn)
          FN_ADD:   sel = SEL_ADD;
          FN_SUB:   sel = SEL_SUB;
          FN_AND:   sel = SEL_AND;
          FN_OR:    sel = SEL_OR;
          FN_SLT:   sel = SEL_SLT;
          FN_MFHI:  sel = SEL_MFHI;
          FN_MFLO:  sel = SEL_MFLO;
          FN_MULT:  sel = SEL_MULT;
          FN_MULTU: sel = SEL_MULTU;
          FN_DIV:   sel = SEL_DIV;
          FN_DIVU:  sel = SEL_DIVU;
          default:  sel = SEL_NOP;
        endcase
      end
      default: sel = SEL_NOP;
    endcase
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_iter.sv
// +--------------------------------------------------------------------------+
// | muldiv_iter : one-bit-per-cycle unsigned shift-add / restoring divider   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic                 div_i,
  input  logic [WIDTH-1:0]     init_i,
  input  logic [WIDTH-1:0]     opnd_i,
  output logic [CNT_W-1:0]     cnt_o,
  output logic [2*WIDTH-1:0]   acc_o
);

  // acc holds {partial (WIDTH+1 bits), multiplier/quotient (WIDTH bits)}
  logic [2*WIDTH:0] acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;

  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    w_sum  = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    w_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    if (load_i) begin
      acc_d  = {{(WIDTH+1){1'b0}}, init_i};
      opnd_d = opnd_i;
      cnt_d  = CNT_W'(WIDTH);
    end else if (step_i) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (div_i) begin
        // borrow out of the trial subtract means remainder < divisor: restore
        if (w_diff[WIDTH]) acc_d = {acc_q[2*WIDTH-1:0], 1'b0};
        else               acc_d = {w_diff, acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {1'b0, w_sum, acc_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign acc_o = acc_q[2*WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/alu_muldiv_ctrl.sv
// +--------------------------------------------------------------------------+
// | alu_muldiv_ctrl : EX-stage ALU decode, mul/div sequencing and HI/LO      |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_muldiv_ctrl
  import mips_ex_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [SEL_W-1:0] select,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  md_state_e          state_q, state_d;
  logic [3:0]         w_sel;
  logic               w_is_mul, w_is_div, w_is_signed, w_hilo_op;
  logic               w_load, w_step, w_fin;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [CNT_W-1:0]   w_cnt;
  logic [2*WIDTH-1:0] w_acc, w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;
  logic               signed_q, div_q, neg_a_q, neg_b_q, div0_q, done_q;
  logic [WIDTH-1:0]   a_q, hi_q, hi_d, lo_q, lo_d;

  assign w_sel       = decode_sel(alu_op, funct);
  assign select      = SEL_W'(w_sel);
  assign w_is_mul    = (w_sel == SEL_MULT) || (w_sel == SEL_MULTU);
  assign w_is_div    = (w_sel == SEL_DIV)  || (w_sel == SEL_DIVU);
  assign w_is_signed = (w_sel == SEL_MULT) || (w_sel == SEL_DIV);
  assign w_hilo_op   = w_is_mul || w_is_div || (w_sel == SEL_MFHI) || (w_sel == SEL_MFLO);
  assign w_mag_a     = (w_is_signed && a[WIDTH-1]) ? -a : a;
  assign w_mag_b     = (w_is_signed && b[WIDTH-1]) ? -b : b;

  always_comb begin
    state_d = state_q;
    w_load  = 1'b0;
    w_step  = 1'b0;
    w_fin   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && w_is_mul) begin
          state_d = ST_MUL;
          w_load  = 1'b1;
        end else if (start && w_is_div) begin
          state_d = ST_DIV;
          w_load  = 1'b1;
        end
      end
      ST_MUL, ST_DIV: begin
        w_step = 1'b1;
        if (w_cnt == CNT_W'(1)) state_d = ST_FIN;
      end
      ST_FIN: begin
        w_fin   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (w_load),
    .step_i (w_step),
    .div_i  (state_q == ST_DIV),
    .init_i (w_is_div ? w_mag_a : w_mag_b),
    .opnd_i (w_is_div ? w_mag_b : w_mag_a),
    .cnt_o  (w_cnt),
    .acc_o  (w_acc)
  );

  // Magnitude results are re-signed here; remainder follows the dividend
  assign w_prod = (signed_q && (neg_a_q ^ neg_b_q)) ? -w_acc : w_acc;
  assign w_quo  = (signed_q && (neg_a_q ^ neg_b_q)) ? -w_acc[WIDTH-1:0] : w_acc[WIDTH-1:0];
  assign w_rem  = (signed_q && neg_a_q) ? -w_acc[2*WIDTH-1:WIDTH] : w_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (w_fin) begin
      if (!div_q) begin
        hi_d = w_prod[2*WIDTH-1:WIDTH];
        lo_d = w_prod[WIDTH-1:0];
      end else if (div0_q) begin
        hi_d = a_q;
        lo_d = '1;
      end else begin
        hi_d = w_rem;
        lo_d = w_quo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      signed_q <= 1'b0;
      div_q    <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      div0_q   <= 1'b0;
      a_q      <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= w_fin;
      if (w_load) begin
        signed_q <= w_is_signed;
        div_q    <= w_is_div;
        neg_a_q  <= w_is_signed && a[WIDTH-1];
        neg_b_q  <= w_is_signed && b[WIDTH-1];
        div0_q   <= (b == '0);
        a_q      <= a;
      end
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign stall = busy && start && w_hilo_op;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

`default_nettype wire
